cpu_control_sequencer: RTL

- Hardwired control unit for the 32-bit single-bus CPU datapath (R0–R15, PC, IR, Y, Z, MAR, MDR).
- Runs the fetch/decode/execute state machine and drives every register-enable, bus-drive, ALU-op and memory strobe, one state per clock.
- Sits beside the datapath; it reads IR and a memory-ready handshake and drives the datapath control inputs.
- Guarantees at most one bus driver per cycle, so the bus encoder always sees a single source.

---
 rtl/cpu_ctrl_pkg.sv | 88 ++++++++
 rtl/cpu_opcode_decoder.sv | 35 +++
 rtl/cpu_control_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared constants and types for the CPU control sequencer
package cpu_ctrl_pkg;

  // IR field bit positions
  localparam int IR_OPC_MSB = 31;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_MSB  = 18;
  localparam int IR_RC_LSB  = 15;
  localparam int IR_C_MSB   = 18;
  localparam int IR_C_LSB   = 0;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_ANDI = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation encodings
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;

  // Sequencer states
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F0   = 4'd1;
  localparam logic [3:0] S_F1   = 4'd2;
  localparam logic [3:0] S_F2   = 4'd3;
  localparam logic [3:0] S_E3   = 4'd4;
  localparam logic [3:0] S_E4   = 4'd5;
  localparam logic [3:0] S_E5   = 4'd6;
  localparam logic [3:0] S_E6   = 4'd7;
  localparam logic [3:0] S_E7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LD,
    CLS_LDI,
    CLS_ST,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_e;

  // One registered control word driving the datapath
  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       r_out;
    logic       ba_out;
    logic       c_out;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       y_in;
    logic       z_in;
    logic       r_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       run;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_opcode_decoder.sv
// rtl/cpu_opcode_decoder.sv - combinational opcode to instruction class and ALU op
module cpu_opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opcode,
  output instr_class_e     o_class,
  output logic [3:0]       o_alu_op
);

  // Classify the opcode; address-forming classes (ld/ldi/st) always add
  always_comb begin
    o_class  = CLS_ILLEGAL;
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OP_LD:   o_class = CLS_LD;
      OP_LDI:  o_class = CLS_LDI;
      OP_ST:   o_class = CLS_ST;
      OP_ADD:  begin o_class = CLS_RTYPE; o_alu_op = ALU_ADD; end
      OP_SUB:  begin o_class = CLS_RTYPE; o_alu_op = ALU_SUB; end
      OP_AND:  begin o_class = CLS_RTYPE; o_alu_op = ALU_AND; end
      OP_OR:   begin o_class = CLS_RTYPE; o_alu_op = ALU_OR;  end
      OP_SHR:  begin o_class = CLS_RTYPE; o_alu_op = ALU_SHR; end
      OP_SHL:  begin o_class = CLS_RTYPE; o_alu_op = ALU_SHL; end
      OP_ADDI: begin o_class = CLS_ITYPE; o_alu_op = ALU_ADD; end
      OP_ANDI: begin o_class = CLS_ITYPE; o_alu_op = ALU_AND; end
      OP_ORI:  begin o_class = CLS_ITYPE; o_alu_op = ALU_OR;  end
      OP_NOP:  o_class = CLS_NOP;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - hardwired fetch/decode/execute sequencer for the single-bus CPU
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W           = 5,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        zlow_out,
  output logic        mdr_out,
  output logic        r_out,
  output logic        ba_out,
  output logic        c_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        r_in,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        inc_pc,
  output logic [3:0]  alu_op,
  output logic        read,
  output logic        write,
  output logic        run,
  output logic        illegal
);

  logic [3:0]   r_state;
  logic [3:0]   w_nxt;
  ctrl_t        r_ctrl;
  ctrl_t        w_ctrl;
  logic         r_illegal;
  instr_class_e w_class;
  logic [3:0]   w_alu_op;
  logic         w_ldst;
  logic         w_unused_ir;

  // Operand fields are consumed by the datapath, not by the sequencer
  assign w_unused_ir = ^{ir[IR_RA_MSB:IR_RA_LSB], ir[IR_RB_MSB:IR_RB_LSB],
                         ir[IR_RC_MSB:IR_RC_LSB], ir[IR_C_MSB:IR_C_LSB]};

  // ir must already hold the fetched instruction at the F2->E3 edge, because
  // E3's control word is registered off that edge.
  cpu_opcode_decoder #(
    .OPC_W (OPC_W)
  ) u_dec (
    .i_opcode (ir[IR_OPC_MSB -: OPC_W]),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

  assign w_ldst = (w_class == CLS_LD) || (w_class == CLS_ST);

  // Next-state selection; mem_ready only matters in the three wait states
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_nxt = S_F0;
      S_F0:   w_nxt = S_F1;
      S_F1:   if (mem_ready) w_nxt = S_F2;
      S_F2:   w_nxt = S_E3;
      S_E3: begin
        case (w_class)
          CLS_NOP:     w_nxt = S_F0;
          CLS_HALT:    w_nxt = S_HALT;
          CLS_ILLEGAL: w_nxt = HALT_ON_ILLEGAL ? S_HALT : S_F0;
          default:     w_nxt = S_E4;
        endcase
      end
      S_E4:   w_nxt = S_E5;
      S_E5:   w_nxt = w_ldst ? S_E6 : S_F0;
      S_E6:   if ((w_class == CLS_ST) || mem_ready) w_nxt = S_E7;
      S_E7:   if ((w_class == CLS_LD) || mem_ready) w_nxt = S_F0;
      S_HALT: w_nxt = S_HALT;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops
  always_comb begin
    w_ctrl = '0;
    case (w_nxt)
      S_F0: begin
        w_ctrl.pc_out = 1'b1;
        w_ctrl.mar_in = 1'b1;
        w_ctrl.inc_pc = 1'b1;
        w_ctrl.z_in   = 1'b1;
      end
      S_F1: begin
        w_ctrl.read   = 1'b1;
        w_ctrl.mdr_in = 1'b1;
        // PC update happens once, on entry; the rest of F1 just waits on memory
        if (r_state != S_F1) begin
          w_ctrl.zlow_out = 1'b1;
          w_ctrl.pc_in    = 1'b1;
        end
      end
      S_F2: begin
        w_ctrl.mdr_out = 1'b1;
        w_ctrl.ir_in   = 1'b1;
      end
      S_E3: begin
        case (w_class)
          CLS_RTYPE, CLS_ITYPE: begin
            w_ctrl.grb   = 1'b1;
            w_ctrl.r_out = 1'b1;
            w_ctrl.y_in  = 1'b1;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            w_ctrl.grb    = 1'b1;
            w_ctrl.ba_out = 1'b1;
            w_ctrl.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      S_E4: begin
        w_ctrl.z_in   = 1'b1;
        w_ctrl.alu_op = w_alu_op;
        if (w_class == CLS_RTYPE) begin
          w_ctrl.grc   = 1'b1;
          w_ctrl.r_out = 1'b1;
        end else begin
          w_ctrl.c_out = 1'b1;
        end
      end
      S_E5: begin
        w_ctrl.zlow_out = 1'b1;
        if (w_ldst) begin
          w_ctrl.mar_in = 1'b1;
        end else begin
          w_ctrl.gra  = 1'b1;
          w_ctrl.r_in = 1'b1;
        end
      end
      S_E6: begin
        w_ctrl.mdr_in = 1'b1;
        // Store loads MDR from the bus (read low); load waits on memory
        if (w_class == CLS_LD) begin
          w_ctrl.read = 1'b1;
        end else begin
          w_ctrl.gra   = 1'b1;
          w_ctrl.r_out = 1'b1;
        end
      end
      S_E7: begin
        if (w_class == CLS_LD) begin
          w_ctrl.mdr_out = 1'b1;
          w_ctrl.gra     = 1'b1;
          w_ctrl.r_in    = 1'b1;
        end else begin
          w_ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
    w_ctrl.run = (w_nxt != S_IDLE) && (w_nxt != S_HALT);
  end

  // State, control word and sticky illegal flag; reset drops every strobe at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ctrl  <= w_ctrl;
      if ((r_state == S_F2) && (w_class == CLS_ILLEGAL)) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign pc_out   = r_ctrl.pc_out;
  assign zlow_out = r_ctrl.zlow_out;
  assign mdr_out  = r_ctrl.mdr_out;
  assign r_out    = r_ctrl.r_out;
  assign ba_out   = r_ctrl.ba_out;
  assign c_out    = r_ctrl.c_out;
  assign pc_in    = r_ctrl.pc_in;
  assign ir_in    = r_ctrl.ir_in;
  assign mar_in   = r_ctrl.mar_in;
  assign mdr_in   = r_ctrl.mdr_in;
  assign y_in     = r_ctrl.y_in;
  assign z_in     = r_ctrl.z_in;
  assign r_in     = r_ctrl.r_in;
  assign gra      = r_ctrl.gra;
  assign grb      = r_ctrl.grb;
  assign grc      = r_ctrl.grc;
  assign inc_pc   = r_ctrl.inc_pc;
  assign alu_op   = r_ctrl.alu_op;
  assign read     = r_ctrl.read;
  assign write    = r_ctrl.write;
  assign run      = r_ctrl.run;
  assign illegal  = r_illegal;

  // Single bus source per cycle, and never read and write together
  a_bus_single: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({pc_out, zlow_out, mdr_out, r_out, ba_out, c_out}) && !(read && write));

endmodule
